// File: rtl/ct_lsu_lq_pkg.sv
// Load queue shared types and helpers.
// Default sizing, fail FSM states and a population count.
package ct_lsu_lq_pkg;

    localparam int LQ_ENTRY_NUM = 16;
    localparam int LQ_IID_W     = 7;
    localparam int LQ_CNT_W     = $clog2(LQ_ENTRY_NUM + 1);

    typedef enum logic {
        LQ_IDLE = 1'b0,
        LQ_FAIL = 1'b1
    } lq_fsm_e;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ct_lsu_lq_free_sel.sv
// Find-first-two selector over a free vector.
// Gives one-hot lowest/second-lowest set bits and the set-bit count.
module ct_lsu_lq_free_sel
    import ct_lsu_lq_pkg::*;
#(
    parameter int ENTRY_NUM = LQ_ENTRY_NUM,
    parameter int CNT_W     = LQ_CNT_W
) (
    input  logic [ENTRY_NUM-1:0] free_x,
    output logic [ENTRY_NUM-1:0] onehot0,
    output logic [ENTRY_NUM-1:0] onehot1,
    output logic [CNT_W-1:0]     free_cnt
);

    logic found0;
    logic found1;

    // Scan upward; first set bit goes to onehot0, second to onehot1.
    always_comb begin
        onehot0 = '0;
        onehot1 = '0;
        found0  = 1'b0;
        found1  = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (free_x[i]) begin
                if (!found0) begin
                    onehot0[i] = 1'b1;
                    found0     = 1'b1;
                end else if (!found1) begin
                    onehot1[i] = 1'b1;
                    found1     = 1'b1;
                end
            end
        end
        free_cnt = CNT_W'(popcount(64'(free_x)));
    end

endmodule

// File: rtl/ct_lsu_lq_alloc_ctrl.sv
// Load queue allocation and speculation-fail controller.
// Picks entries for DC loads, flags replay, tracks occupancy and fails.
module ct_lsu_lq_alloc_ctrl
    import ct_lsu_lq_pkg::*;
#(
    parameter int ENTRY_NUM = LQ_ENTRY_NUM,
    parameter int IID_W     = LQ_IID_W,
    parameter int CNT_W     = LQ_CNT_W
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    input  logic                 ld_dc_inst_chk_vld,
    input  logic                 ld_dc_chk_ld_addr1_vld,
    input  logic [IID_W-1:0]     ld_dc_iid,
    input  logic                 rtu_yy_xx_flush,
    input  logic [ENTRY_NUM-1:0] lq_entry_vld_x,
    input  logic [ENTRY_NUM-1:0] lq_entry_inst_hit_x,
    input  logic [ENTRY_NUM-1:0] lq_entry_rar_spec_fail_x,
    input  logic [ENTRY_NUM-1:0] lq_entry_raw_spec_fail_x,
    output logic [ENTRY_NUM-1:0] lq_create0_vld_x,
    output logic [ENTRY_NUM-1:0] lq_create1_vld_x,
    output logic [ENTRY_NUM-1:0] lq_create0_dp_vld_x,
    output logic [ENTRY_NUM-1:0] lq_create1_dp_vld_x,
    output logic [ENTRY_NUM-1:0] lq_create_gateclk_en_x,
    output logic                 lq_ld_dc_replay,
    output logic                 lq_full,
    output logic [CNT_W-1:0]     lq_entry_cnt,
    output logic                 lq_spec_fail_req,
    output logic [1:0]           lq_spec_fail_type
);

    lq_fsm_e              state;
    logic [ENTRY_NUM-1:0] sel0;
    logic [ENTRY_NUM-1:0] sel1;
    logic [CNT_W-1:0]     free_cnt;
    logic [CNT_W-1:0]     alloc_num;
    logic [1:0]           need;
    logic                 hit;
    logic                 cap_ok;
    logic                 create_en;
    logic                 split;
    logic                 rar_any;
    logic                 raw_any;
    logic                 unused_iid;

    // The iid is carried for trace only.
    assign unused_iid = ^ld_dc_iid;

    ct_lsu_lq_free_sel #(
        .ENTRY_NUM(ENTRY_NUM),
        .CNT_W    (CNT_W)
    ) u_free_sel (
        .free_x  (~lq_entry_vld_x),
        .onehot0 (sel0),
        .onehot1 (sel1),
        .free_cnt(free_cnt)
    );

    // Request decode, create strobes and replay decision.
    always_comb begin
        split     = ld_dc_inst_chk_vld && ld_dc_chk_ld_addr1_vld;
        need      = ld_dc_inst_chk_vld ? (split ? 2'd2 : 2'd1) : 2'd0;
        hit       = |lq_entry_inst_hit_x;
        cap_ok    = free_cnt >= CNT_W'(need);
        create_en = (need != 2'd0) && !hit && cap_ok
                    && !rtu_yy_xx_flush && (state == LQ_IDLE);
        lq_create0_vld_x = create_en ? sel0 : '0;
        lq_create1_vld_x = (create_en && split) ? sel1 : '0;
        lq_create0_dp_vld_x = lq_create0_vld_x;
        lq_create1_dp_vld_x = lq_create1_vld_x;
        lq_create_gateclk_en_x = (ld_dc_inst_chk_vld ? sel0 : '0)
                               | (split ? sel1 : '0);
        lq_ld_dc_replay = (need != 2'd0) && !hit
                          && (!cap_ok || state == LQ_FAIL)
                          && !rtu_yy_xx_flush;
        alloc_num = CNT_W'(create_en) + CNT_W'(create_en && split);
        rar_any   = |lq_entry_rar_spec_fail_x;
        raw_any   = |lq_entry_raw_spec_fail_x;
    end

    // Occupancy and near-full flags, one cycle behind the entry array.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            lq_entry_cnt <= '0;
            lq_full      <= 1'b0;
        end else begin
            lq_entry_cnt <= CNT_W'(popcount(64'(lq_entry_vld_x)));
            lq_full      <= (free_cnt - alloc_num) < CNT_W'(2);
        end
    end

    // Sticky speculation-fail FSM; flush always wins over a new fail.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state             <= LQ_IDLE;
            lq_spec_fail_req  <= 1'b0;
            lq_spec_fail_type <= 2'b00;
        end else begin
            unique case (state)
                LQ_IDLE: begin
                    if ((rar_any || raw_any) && !rtu_yy_xx_flush) begin
                        state             <= LQ_FAIL;
                        lq_spec_fail_req  <= 1'b1;
                        lq_spec_fail_type <= {raw_any, rar_any};
                    end
                end
                LQ_FAIL: begin
                    if (rtu_yy_xx_flush) begin
                        state             <= LQ_IDLE;
                        lq_spec_fail_req  <= 1'b0;
                        lq_spec_fail_type <= 2'b00;
                    end else begin
                        lq_spec_fail_type <= lq_spec_fail_type
                                           | {raw_any, rar_any};
                    end
                end
                default: begin
                    state            <= LQ_IDLE;
                    lq_spec_fail_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_lsu_lq_alloc_ctrl.sv
// Directed bench for the load queue allocation controller.
// Hand-computed expectations checked with immediate assertions.
module tb_ct_lsu_lq_alloc_ctrl;

    logic        forever_cpuclk;
    logic        cpurst;
    logic        ld_dc_inst_chk_vld;
    logic        ld_dc_chk_ld_addr1_vld;
    logic [6:0]  ld_dc_iid;
    logic        rtu_yy_xx_flush;
    logic [15:0] vld_x;
    logic [15:0] hit_x;
    logic [15:0] rar_x;
    logic [15:0] raw_x;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] gate;
    logic        replay;
    logic        full;
    logic [4:0]  cnt;
    logic        req;
    logic [1:0]  ftype;

    int checks = 0;
    int errors = 0;

    ct_lsu_lq_alloc_ctrl dut (
        .forever_cpuclk          (forever_cpuclk),
        .cpurst                  (cpurst),
        .ld_dc_inst_chk_vld      (ld_dc_inst_chk_vld),
        .ld_dc_chk_ld_addr1_vld  (ld_dc_chk_ld_addr1_vld),
        .ld_dc_iid               (ld_dc_iid),
        .rtu_yy_xx_flush         (rtu_yy_xx_flush),
        .lq_entry_vld_x          (vld_x),
        .lq_entry_inst_hit_x     (hit_x),
        .lq_entry_rar_spec_fail_x(rar_x),
        .lq_entry_raw_spec_fail_x(raw_x),
        .lq_create0_vld_x        (c0),
        .lq_create1_vld_x        (c1),
        .lq_create0_dp_vld_x     (d0),
        .lq_create1_dp_vld_x     (d1),
        .lq_create_gateclk_en_x  (gate),
        .lq_ld_dc_replay         (replay),
        .lq_full                 (full),
        .lq_entry_cnt            (cnt),
        .lq_spec_fail_req        (req),
        .lq_spec_fail_type       (ftype)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge forever_cpuclk);
        #1;
    endtask

    initial begin
        cpurst = 1'b1;
        ld_dc_inst_chk_vld = 1'b0;
        ld_dc_chk_ld_addr1_vld = 1'b0;
        ld_dc_iid = 7'd5;
        rtu_yy_xx_flush = 1'b0;
        vld_x = '0;
        hit_x = '0;
        rar_x = '0;
        raw_x = '0;
        edge1();
        edge1();
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_type", 32'(ftype), 32'd0);
        cpurst = 1'b0;

        // 1: empty queue, single load
        ld_dc_inst_chk_vld = 1'b1;
        #1;
        chk("t1_c0", 32'(c0), 32'h0001);
        chk("t1_c1", 32'(c1), 32'h0000);
        chk("t1_d0", 32'(d0), 32'h0001);
        chk("t1_gate", 32'(gate), 32'h0001);
        chk("t1_replay", 32'(replay), 32'd0);
        edge1();
        chk("t1_cnt", 32'(cnt), 32'd0);
        chk("t1_full", 32'(full), 32'd0);

        // 2: split load into upper half
        vld_x = 16'h00FF;
        ld_dc_chk_ld_addr1_vld = 1'b1;
        #1;
        chk("t2_c0", 32'(c0), 32'h0100);
        chk("t2_c1", 32'(c1), 32'h0200);
        chk("t2_d1", 32'(d1), 32'h0200);
        chk("t2_gate", 32'(gate), 32'h0300);
        chk("t2_replay", 32'(replay), 32'd0);
        edge1();
        chk("t2_cnt", 32'(cnt), 32'd8);
        chk("t2_full", 32'(full), 32'd0);

        // 3: one free entry
        vld_x = 16'hFFFE;
        #1;
        chk("t3s_replay", 32'(replay), 32'd1);
        chk("t3s_c0", 32'(c0), 32'h0000);
        chk("t3s_c1", 32'(c1), 32'h0000);
        chk("t3s_gate", 32'(gate), 32'h0001);
        edge1();
        chk("t3s_full", 32'(full), 32'd1);
        chk("t3s_cnt", 32'(cnt), 32'd15);
        ld_dc_chk_ld_addr1_vld = 1'b0;
        #1;
        chk("t3_c0", 32'(c0), 32'h0001);
        chk("t3_replay", 32'(replay), 32'd0);
        edge1();
        chk("t3_full", 32'(full), 32'd1);
        vld_x = 16'hFFFF;
        #1;
        chk("t3f_replay", 32'(replay), 32'd1);
        chk("t3f_c0", 32'(c0), 32'h0000);
        edge1();
        chk("t3f_cnt", 32'(cnt), 32'd16);

        // 4: existing entry hit, then flush with request
        vld_x = '0;
        hit_x = 16'h0004;
        ld_dc_chk_ld_addr1_vld = 1'b1;
        #1;
        chk("t4h_c0", 32'(c0), 32'h0000);
        chk("t4h_c1", 32'(c1), 32'h0000);
        chk("t4h_replay", 32'(replay), 32'd0);
        edge1();
        chk("t4h_full", 32'(full), 32'd0);
        hit_x = '0;
        ld_dc_chk_ld_addr1_vld = 1'b0;
        rtu_yy_xx_flush = 1'b1;
        #1;
        chk("t4f_c0", 32'(c0), 32'h0000);
        chk("t4f_replay", 32'(replay), 32'd0);
        chk("t4f_gate", 32'(gate), 32'h0001);
        edge1();
        rtu_yy_xx_flush = 1'b0;

        // 5: speculation fail sequence
        ld_dc_inst_chk_vld = 1'b0;
        raw_x = 16'h0008;
        edge1();
        chk("t5_req", 32'(req), 32'd1);
        chk("t5_type", 32'(ftype), 32'b10);
        raw_x = '0;
        rar_x = 16'h0020;
        edge1();
        chk("t5_type2", 32'(ftype), 32'b11);
        rar_x = '0;
        ld_dc_inst_chk_vld = 1'b1;
        #1;
        chk("t5_replay", 32'(replay), 32'd1);
        chk("t5_c0", 32'(c0), 32'h0000);
        edge1();
        chk("t5_hold", 32'(req), 32'd1);
        ld_dc_inst_chk_vld = 1'b0;
        rtu_yy_xx_flush = 1'b1;
        edge1();
        chk("t5f_req", 32'(req), 32'd0);
        chk("t5f_type", 32'(ftype), 32'd0);
        raw_x = 16'h0001;
        edge1();
        chk("t5d_req", 32'(req), 32'd0);
        rtu_yy_xx_flush = 1'b0;

        // 6: reset while failing and full
        vld_x = 16'hFFFF;
        edge1();
        raw_x = '0;
        chk("t6_req", 32'(req), 32'd1);
        chk("t6_full", 32'(full), 32'd1);
        chk("t6_cnt", 32'(cnt), 32'd16);
        cpurst = 1'b1;
        edge1();
        chk("t6r_req", 32'(req), 32'd0);
        chk("t6r_type", 32'(ftype), 32'd0);
        chk("t6r_full", 32'(full), 32'd0);
        chk("t6r_cnt", 32'(cnt), 32'd0);
        cpurst = 1'b0;
        vld_x = '0;
        ld_dc_inst_chk_vld = 1'b1;
        #1;
        chk("t6_idle_c0", 32'(c0), 32'h0001);
        chk("t6_idle_rp", 32'(replay), 32'd0);
        edge1();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
